// File: rtl/tcm_arb_pkg.sv
// Shared types for the TCM data-port arbiter: requester IDs and the requester count.
package tcm_arb_pkg;

    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_SPI  = 1'b1
    } req_id_t;

    localparam int N_REQ = 2;

endpackage

// File: rtl/tcm_arb_tag_fifo.sv
// In-order FIFO of requester IDs, one entry per accepted-but-unacknowledged transaction.
module tcm_arb_tag_fifo
    import tcm_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  req_id_t push_id_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output req_id_t head_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    req_id_t       mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (do_push && !do_pop)      count_d = count_q + CW'(1);
        else if (!do_push && do_pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_id_i;
    end

endmodule

// File: rtl/tcm_dport_arb.sv
// Round-robin arbiter with SPI lock sharing the TCM data port between the core LSU and the
// SPI loader; responses are steered back in order using a tag FIFO.
module tcm_dport_arb
    import tcm_arb_pkg::*;
#(
    parameter int OUTST_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_data_wr_i,
    input  logic        core_rd_i,
    input  logic [3:0]  core_wr_i,
    output logic        core_accept_o,
    output logic        core_ack_o,
    output logic [31:0] core_data_rd_o,
    output logic        core_error_o,

    input  logic [31:0] spi_addr_i,
    input  logic [31:0] spi_data_wr_i,
    input  logic        spi_rd_i,
    input  logic [3:0]  spi_wr_i,
    output logic        spi_accept_o,
    output logic        spi_ack_o,
    output logic [31:0] spi_data_rd_o,
    output logic        spi_error_o,

    input  logic        spi_lock_i,

    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_wr_o,
    output logic        mem_rd_o,
    output logic [3:0]  mem_wr_o,
    input  logic        mem_accept_i,
    input  logic        mem_ack_i,
    input  logic        mem_error_i,
    input  logic [31:0] mem_data_rd_i,

    output logic        busy_o,
    output logic        spurious_o
);

    // Handshake: a request is (rd | |wr); it completes in the cycle accept is high, and a
    // requester keeps its request stable until then. A stalled request keeps the grant.
    logic [N_REQ-1:0] req_vld;
    req_id_t          gnt;
    logic             gnt_vld;
    logic             fwd;
    logic             acc;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    req_id_t          fifo_head;

    logic    hold_q, hold_d;
    req_id_t gnt_q, gnt_d;
    req_id_t last_q, last_d;
    logic    spurious_q, spurious_d;

    assign req_vld[0] = (core_rd_i | (|core_wr_i)) & ~spi_lock_i;
    assign req_vld[1] = spi_rd_i | (|spi_wr_i);

    always_comb begin
        gnt = gnt_q;
        if (!hold_q) begin
            if (&req_vld)        gnt = (last_q == REQ_CORE) ? REQ_SPI : REQ_CORE;
            else if (req_vld[1]) gnt = REQ_SPI;
            else                 gnt = REQ_CORE;
        end
    end

    assign gnt_vld = (gnt == REQ_SPI) ? req_vld[1] : req_vld[0];
    assign fwd     = gnt_vld & ~fifo_full;
    assign acc     = fwd & mem_accept_i;
    assign pop     = mem_ack_i & ~fifo_empty;

    assign mem_addr_o    = (gnt == REQ_SPI) ? spi_addr_i : core_addr_i;
    assign mem_data_wr_o = (gnt == REQ_SPI) ? spi_data_wr_i : core_data_wr_i;
    assign mem_rd_o      = fwd & ((gnt == REQ_SPI) ? spi_rd_i : core_rd_i);
    assign mem_wr_o      = fwd ? ((gnt == REQ_SPI) ? spi_wr_i : core_wr_i) : 4'h0;

    assign core_accept_o = acc & (gnt == REQ_CORE);
    assign spi_accept_o  = acc & (gnt == REQ_SPI);

    assign core_ack_o     = pop & (fifo_head == REQ_CORE);
    assign spi_ack_o      = pop & (fifo_head == REQ_SPI);
    assign core_error_o   = core_ack_o & mem_error_i;
    assign spi_error_o    = spi_ack_o & mem_error_i;
    assign core_data_rd_o = mem_data_rd_i;
    assign spi_data_rd_o  = mem_data_rd_i;

    assign busy_o     = ~fifo_empty;
    assign spurious_o = spurious_q;

    // A held requester that drops its request (or is masked by the lock) releases the hold.
    always_comb begin
        hold_d     = hold_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        spurious_d = spurious_q | (mem_ack_i & fifo_empty);
        if (acc) begin
            hold_d = 1'b0;
            last_d = gnt;
        end else if (gnt_vld) begin
            hold_d = 1'b1;
            gnt_d  = gnt;
        end else begin
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q     <= 1'b0;
            gnt_q      <= REQ_CORE;
            last_q     <= REQ_SPI;
            spurious_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            spurious_q <= spurious_d;
        end
    end

    tcm_arb_tag_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_tag_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push_i    (acc),
        .push_id_i (gnt),
        .pop_i     (pop),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .head_o    (fifo_head)
    );

endmodule

// File: tb/tb_tcm_dport_arb.sv
// Bench for tcm_dport_arb: directed scenarios with literal expectations plus a randomized run,
// all compared every cycle against a queue-based reference of the arbitration rules.
module tb_tcm_dport_arb;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr_i, core_data_wr_i, spi_addr_i, spi_data_wr_i;
    logic        core_rd_i, spi_rd_i;
    logic [3:0]  core_wr_i, spi_wr_i;
    logic        core_accept_o, core_ack_o, core_error_o;
    logic        spi_accept_o, spi_ack_o, spi_error_o;
    logic [31:0] core_data_rd_o, spi_data_rd_o;
    logic        spi_lock_i;
    logic [31:0] mem_addr_o, mem_data_wr_o, mem_data_rd_i;
    logic        mem_rd_o;
    logic [3:0]  mem_wr_o;
    logic        mem_accept_i, mem_ack_i, mem_error_i;
    logic        busy_o, spurious_o;

    always #5 clk = ~clk;

    tcm_dport_arb #(.OUTST_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .core_addr_i(core_addr_i), .core_data_wr_i(core_data_wr_i),
        .core_rd_i(core_rd_i), .core_wr_i(core_wr_i),
        .core_accept_o(core_accept_o), .core_ack_o(core_ack_o),
        .core_data_rd_o(core_data_rd_o), .core_error_o(core_error_o),
        .spi_addr_i(spi_addr_i), .spi_data_wr_i(spi_data_wr_i),
        .spi_rd_i(spi_rd_i), .spi_wr_i(spi_wr_i),
        .spi_accept_o(spi_accept_o), .spi_ack_o(spi_ack_o),
        .spi_data_rd_o(spi_data_rd_o), .spi_error_o(spi_error_o),
        .spi_lock_i(spi_lock_i),
        .mem_addr_o(mem_addr_o), .mem_data_wr_o(mem_data_wr_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_accept_i(mem_accept_i), .mem_ack_i(mem_ack_i),
        .mem_error_i(mem_error_i), .mem_data_rd_i(mem_data_rd_i),
        .busy_o(busy_o), .spurious_o(spurious_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: queue of outstanding requester IDs (0 core, 1 spi) plus the grant memory.
    int m_q[$];
    int m_hold, m_gnt, m_last;
    bit m_spur;

    task automatic model_eval(output int g, output bit v, output bit fwd,
                              output bit acc, output bit pop, output int head);
        bit cv, sv;
        cv = (core_rd_i || core_wr_i != 4'h0) && !spi_lock_i;
        sv = spi_rd_i || spi_wr_i != 4'h0;
        if (m_hold != 0)   g = m_gnt;
        else if (cv && sv) g = 1 - m_last;
        else if (sv)       g = 1;
        else               g = 0;
        v    = (g == 1) ? sv : cv;
        fwd  = v && (m_q.size() < DEPTH);
        acc  = fwd && mem_accept_i;
        pop  = mem_ack_i && (m_q.size() > 0);
        head = (m_q.size() > 0) ? m_q[0] : 0;
    endtask

    always @(posedge clk or posedge rst) begin
        int g, head;
        bit v, fwd, acc, pop;
        if (rst) begin
            m_q.delete();
            m_hold = 0; m_gnt = 0; m_last = 1; m_spur = 0;
        end else begin
            model_eval(g, v, fwd, acc, pop, head);
            if (pop) void'(m_q.pop_front());
            else if (mem_ack_i) m_spur = 1;
            if (acc) begin
                m_q.push_back(g);
                m_last = g;
                m_hold = 0;
            end else if (v) begin
                m_hold = 1;
                m_gnt  = g;
            end else begin
                m_hold = 0;
            end
        end
    end

    // Compare process: every falling edge outside reset.
    always @(negedge clk) begin
        int g, head;
        bit v, fwd, acc, pop;
        if (!rst) begin
            model_eval(g, v, fwd, acc, pop, head);
            check("mem_rd", mem_rd_o, fwd ? ((g == 1) ? spi_rd_i : core_rd_i) : 1'b0);
            check("mem_wr", mem_wr_o, fwd ? ((g == 1) ? spi_wr_i : core_wr_i) : 4'h0);
            if (fwd) check("mem_addr", mem_addr_o, (g == 1) ? spi_addr_i : core_addr_i);
            if (fwd && mem_wr_o != 4'h0)
                check("mem_data_wr", mem_data_wr_o, (g == 1) ? spi_data_wr_i : core_data_wr_i);
            check("core_accept", core_accept_o, acc && g == 0);
            check("spi_accept", spi_accept_o, acc && g == 1);
            check("core_ack", core_ack_o, pop && head == 0);
            check("spi_ack", spi_ack_o, pop && head == 1);
            check("core_error", core_error_o, pop && head == 0 && mem_error_i);
            check("spi_error", spi_error_o, pop && head == 1 && mem_error_i);
            check("core_data_rd", core_data_rd_o, mem_data_rd_i);
            check("spi_data_rd", spi_data_rd_o, mem_data_rd_i);
            check("busy", busy_o, m_q.size() > 0);
            check("spurious", spurious_o, m_spur);
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                            input logic [31:0] data);
        core_rd_i = rd; core_wr_i = wr; core_addr_i = addr; core_data_wr_i = data;
    endtask

    task automatic set_spi(input logic rd, input logic [3:0] wr, input logic [31:0] addr,
                           input logic [31:0] data);
        spi_rd_i = rd; spi_wr_i = wr; spi_addr_i = addr; spi_data_wr_i = data;
    endtask

    task automatic idle_reqs();
        set_core(1'b0, 4'h0, 32'h0, 32'h0);
        set_spi(1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    task automatic auto_ack();
        mem_ack_i = (m_q.size() > 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        idle_reqs();
        repeat (DEPTH + 2) begin
            auto_ack();
            tick();
        end
        mem_ack_i = 1'b0;
    endtask

    initial begin
        int n_acc;
        rst = 1'b1;
        idle_reqs();
        spi_lock_i = 1'b0; mem_accept_i = 1'b0; mem_ack_i = 1'b0;
        mem_error_i = 1'b0; mem_data_rd_i = 32'h0;
        tick();
        tick();
        check("rst_core_accept", core_accept_o, 0);
        check("rst_spi_accept", spi_accept_o, 0);
        check("rst_mem_rd", mem_rd_o, 0);
        check("rst_mem_wr", mem_wr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_spurious", spurious_o, 0);
        rst = 1'b0;

        // Core-only read, acknowledged one cycle later.
        set_core(1'b1, 4'h0, 32'h8000_0010, 32'h0);
        mem_accept_i = 1'b1;
        #1;
        check("t1_mem_rd", mem_rd_o, 1);
        check("t1_mem_addr", mem_addr_o, 32'h8000_0010);
        check("t1_core_accept", core_accept_o, 1);
        tick();
        idle_reqs();
        mem_ack_i = 1'b1; mem_data_rd_i = 32'h1234_5678;
        #1;
        check("t1_core_ack", core_ack_o, 1);
        check("t1_core_data", core_data_rd_o, 32'h1234_5678);
        check("t1_spi_ack", spi_ack_o, 0);
        tick();
        mem_ack_i = 1'b0;

        // Both requesting every cycle: strict alternation starting with the core.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            if (i < 6) begin
                set_core(1'b1, 4'h0, 32'h0000_1000, 32'h0);
                set_spi(1'b1, 4'h0, 32'h0000_2000, 32'h0);
            end else begin
                idle_reqs();
            end
            mem_ack_i = (i > 0);
            mem_data_rd_i = $urandom;
            #1;
            if (i < 6) begin
                check("t2_core_gnt", core_accept_o, (i % 2) == 0);
                check("t2_spi_gnt", spi_accept_o, (i % 2) == 1);
            end
            if (i > 0) check("t2_core_ack", core_ack_o, ((i - 1) % 2) == 0);
            tick();
        end
        mem_ack_i = 1'b0;

        // SPI lock: only SPI writes get through; core wins right after the lock drops.
        spi_lock_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_core(1'b1, 4'h0, 32'h0000_3000, 32'h0);
            set_spi(1'b0, 4'hF, 32'h0000_4000 + 32'(i * 4), 32'hDEAD_BEEF);
            auto_ack();
            #1;
            check("t3_spi_accept", spi_accept_o, 1);
            check("t3_core_accept", core_accept_o, 0);
            check("t3_mem_wr", mem_wr_o, 4'hF);
            check("t3_mem_data", mem_data_wr_o, 32'hDEAD_BEEF);
            tick();
        end
        spi_lock_i = 1'b0;
        auto_ack();
        #1;
        check("t3_core_after_lock", core_accept_o, 1);
        tick();
        drain();

        // Stalled core request keeps the grant while SPI becomes valid.
        mem_accept_i = 1'b0;
        set_core(1'b1, 4'h0, 32'h0000_0100, 32'h0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) set_spi(1'b1, 4'h0, 32'h0000_0200, 32'h0);
            #1;
            check("t4_held_addr", mem_addr_o, 32'h0000_0100);
            check("t4_spi_blocked", spi_accept_o, 0);
            tick();
        end
        mem_accept_i = 1'b1;
        #1;
        check("t4_core_first", core_accept_o, 1);
        tick();
        set_core(1'b0, 4'h0, 32'h0, 32'h0);
        auto_ack();
        #1;
        check("t4_spi_second", spi_accept_o, 1);
        check("t4_spi_addr", mem_addr_o, 32'h0000_0200);
        tick();
        drain();

        // Outstanding limit: exactly DEPTH accepts with acks held off.
        do_reset();
        n_acc = 0;
        mem_accept_i = 1'b1;
        mem_ack_i = 1'b0;
        set_core(1'b1, 4'h0, 32'h0000_0500, 32'h0);
        for (int i = 0; i < 6; i++) begin
            #1;
            if (core_accept_o) n_acc++;
            tick();
        end
        check("t5_accept_count", n_acc, DEPTH);
        check("t5_busy", busy_o, 1);
        check("t5_stalled", core_accept_o, 0);
        mem_ack_i = 1'b1;
        #1;
        check("t5_first_pop_ack", core_ack_o, 1);
        check("t5_no_fwd_on_pop", core_accept_o, 0);
        tick();
        check("t5_resume", core_accept_o, 1);
        tick();
        drain();

        // Ack with nothing outstanding.
        do_reset();
        mem_ack_i = 1'b1;
        #1;
        check("t6_no_core_ack", core_ack_o, 0);
        check("t6_no_spi_ack", spi_ack_o, 0);
        tick();
        mem_ack_i = 1'b0;
        #1;
        check("t6_spurious_set", spurious_o, 1);
        repeat (3) tick();
        check("t6_spurious_sticky", spurious_o, 1);
        rst = 1'b1;
        #1;
        check("t6_spurious_cleared", spurious_o, 0);
        tick();
        rst = 1'b0;

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            core_rd_i      = ($urandom_range(0, 2) == 0);
            core_wr_i      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            core_addr_i    = $urandom;
            core_data_wr_i = $urandom;
            spi_rd_i       = ($urandom_range(0, 2) == 0);
            spi_wr_i       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            spi_addr_i     = $urandom;
            spi_data_wr_i  = $urandom;
            if ($urandom_range(0, 19) == 0) spi_lock_i = ~spi_lock_i;
            mem_accept_i  = ($urandom_range(0, 3) != 0);
            mem_ack_i     = (m_q.size() > 0) && ($urandom_range(0, 3) != 0);
            mem_error_i   = ($urandom_range(0, 7) == 0);
            mem_data_rd_i = $urandom;
            tick();
        end
        spi_lock_i = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
